// File: rtl/common_bus_sel_ctrl.sv
// common_bus_sel_ctrl
// Common-bus source selector for the Mano datapath. A one-hot select from the
// control unit picks one of NSRC sources onto the shared bus, which is
// registered. Source 0 is the constant-zero source. The memory source may stall
// the transfer until mem_rdy_i arrives, bounded by a timeout. Multi-hot selects
// and memory timeouts raise sticky error flags that err_clr_i clears.
module common_bus_sel_ctrl #(
  parameter int WIDTH   = 16,
  parameter int NSRC    = 8,
  parameter int MEM_IDX = 7,
  parameter int TIMEOUT = 15,
  localparam int SW     = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NSRC*WIDTH-1:0] src_data_i,
  input  logic [NSRC-1:0]       sel_i,
  input  logic                  hold_i,
  input  logic                  mem_rdy_i,
  input  logic                  err_clr_i,
  output logic [WIDTH-1:0]      bus_o,
  output logic                  bus_vld_o,
  output logic [SW-1:0]         bus_src_o,
  output logic                  busy_o,
  output logic                  sel_err_o,
  output logic                  mem_to_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } stateT;

  stateT           state_q, state_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic            busVld_q, busVld_d;
  logic [SW-1:0]   busSrc_q, busSrc_d;
  logic            selErr_q, selErr_d;
  logic            memTo_q, memTo_d;
  logic [CW-1:0]   waitCnt_q, waitCnt_d;

  logic [WIDTH-1:0] selData;
  logic [WIDTH-1:0] memData;
  logic [SW-1:0]    selIdx;
  logic             selNone;
  logic             selMulti;
  logic             selMem;
  logic             waitExpired;
  logic             unusedSrc0;

  // Slice 0 is the hard-wired zero source, so its input bits are never looked at.
  assign unusedSrc0 = ^src_data_i[WIDTH-1:0];

  assign memData     = src_data_i[MEM_IDX*WIDTH +: WIDTH];
  assign selNone     = (sel_i == '0);
  assign selMulti    = |(sel_i & (sel_i - NSRC'(1)));
  assign selMem      = sel_i[MEM_IDX];
  assign waitExpired = (waitCnt_q == CW'(TIMEOUT - 1));

  // Mux the one-hot selected source onto a data word and encode its index; source 0 yields zero.
  always_comb begin
    selData = '0;
    selIdx  = '0;
    for (int i = 1; i < NSRC; i++) begin
      if (sel_i[i]) begin
        selData = src_data_i[i*WIDTH +: WIDTH];
        selIdx  = SW'(i);
      end
    end
  end

  // Next-state logic: decode the select in IDLE, wait for memory or time out in WAIT_MEM.
  always_comb begin
    state_d   = state_q;
    bus_d     = bus_q;
    busVld_d  = busVld_q;
    busSrc_d  = busSrc_q;
    selErr_d  = selErr_q;
    memTo_d   = memTo_q;
    waitCnt_d = waitCnt_q;

    if (err_clr_i) begin
      selErr_d = 1'b0;
      memTo_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!hold_i) begin
          if (selNone) begin
            bus_d    = '0;
            busVld_d = 1'b0;
          end else if (selMulti) begin
            bus_d    = '0;
            busVld_d = 1'b0;
            selErr_d = 1'b1;
          end else if (selMem) begin
            if (mem_rdy_i) begin
              bus_d    = memData;
              busVld_d = 1'b1;
              busSrc_d = SW'(MEM_IDX);
            end else begin
              state_d   = WAIT_MEM;
              waitCnt_d = '0;
              busVld_d  = 1'b0;
            end
          end else begin
            bus_d    = selData;
            busVld_d = 1'b1;
            busSrc_d = selIdx;
          end
        end
      end

      WAIT_MEM: begin
        if (mem_rdy_i) begin
          bus_d     = memData;
          busVld_d  = 1'b1;
          busSrc_d  = SW'(MEM_IDX);
          state_d   = IDLE;
          waitCnt_d = '0;
        end else if (waitExpired) begin
          bus_d     = '0;
          busVld_d  = 1'b0;
          memTo_d   = 1'b1;
          state_d   = IDLE;
          waitCnt_d = '0;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        waitCnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any memory wait and clears the flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bus_q     <= '0;
      busVld_q  <= 1'b0;
      busSrc_q  <= '0;
      selErr_q  <= 1'b0;
      memTo_q   <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      busVld_q  <= busVld_d;
      busSrc_q  <= busSrc_d;
      selErr_q  <= selErr_d;
      memTo_q   <= memTo_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  assign bus_o     = bus_q;
  assign bus_vld_o = busVld_q;
  assign bus_src_o = busSrc_q;
  assign busy_o    = (state_q == WAIT_MEM);
  assign sel_err_o = selErr_q;
  assign mem_to_o  = memTo_q;

endmodule

// File: tb/tb_common_bus_sel_ctrl.sv
// tb_common_bus_sel_ctrl
// Directed scenarios for the common-bus selector with hand-computed expectations.
module tb_common_bus_sel_ctrl;

  localparam int WIDTH = 16;
  localparam int NSRC  = 8;

  logic                  clk;
  logic                  rstN;
  logic [NSRC*WIDTH-1:0] srcData;
  logic [NSRC-1:0]       sel;
  logic                  hold;
  logic                  memRdy;
  logic                  errClr;
  logic [WIDTH-1:0]      bus;
  logic                  busVld;
  logic [2:0]            busSrc;
  logic                  busy;
  logic                  selErr;
  logic                  memTo;

  int testsRun;
  int testsFailed;

  common_bus_sel_ctrl #(
    .WIDTH(WIDTH), .NSRC(NSRC), .MEM_IDX(7), .TIMEOUT(15)
  ) dut (
    .clk_i(clk), .rst_ni(rstN), .src_data_i(srcData), .sel_i(sel), .hold_i(hold),
    .mem_rdy_i(memRdy), .err_clr_i(errClr), .bus_o(bus), .bus_vld_o(busVld),
    .bus_src_o(busSrc), .busy_o(busy), .sel_err_o(selErr), .mem_to_o(memTo)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past one rising edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; srcData = '0; sel = '0; hold = 1'b0; memRdy = 1'b0; errClr = 1'b0;
    #12;
    testsRun++; if (bus !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset bus: got %h want 0000", bus); end
    testsRun++; if (busVld !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset bus_vld: got %b want 0", busVld); end
    testsRun++; if (busSrc !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset bus_src: got %0d want 0", busSrc); end
    testsRun++; if ({busy, selErr, memTo} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset flags: got %b want 000", {busy, selErr, memTo}); end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_select();
    srcData[2*WIDTH +: WIDTH] = 16'hABCD;
    sel = 8'h04;
    tick();
    testsRun++; if (bus !== 16'hABCD) begin testsFailed++; $display("[TB] FAIL sel2 bus: got %h want abcd", bus); end
    testsRun++; if (busVld !== 1'b1) begin testsFailed++; $display("[TB] FAIL sel2 bus_vld: got %b want 1", busVld); end
    testsRun++; if (busSrc !== 3'd2) begin testsFailed++; $display("[TB] FAIL sel2 bus_src: got %0d want 2", busSrc); end
    sel = 8'h00;
    tick();
    testsRun++; if ({bus, busVld} !== {16'h0000, 1'b0}) begin testsFailed++; $display("[TB] FAIL idle bus/vld: got %h/%b want 0000/0", bus, busVld); end
    testsRun++; if (busSrc !== 3'd2) begin testsFailed++; $display("[TB] FAIL idle bus_src kept: got %0d want 2", busSrc); end
    srcData[0 +: WIDTH] = 16'hFFFF;
    sel = 8'h01;
    tick();
    testsRun++; if ({bus, busVld, busSrc} !== {16'h0000, 1'b1, 3'd0}) begin testsFailed++; $display("[TB] FAIL src0 zero: got %h/%b/%0d want 0000/1/0", bus, busVld, busSrc); end
    sel = 8'h00;
    tick();
  endtask

  task automatic test_mem_wait();
    srcData[7*WIDTH +: WIDTH] = 16'h1234;
    sel = 8'h80; memRdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      sel = 8'h00;
      testsRun++; if ({busy, busVld} !== 2'b10) begin testsFailed++; $display("[TB] FAIL memwait cycle %0d busy/vld: got %b%b want 10", c, busy, busVld); end
    end
    memRdy = 1'b1;
    tick();
    memRdy = 1'b0;
    testsRun++; if ({bus, busVld, busy} !== {16'h1234, 1'b1, 1'b0}) begin testsFailed++; $display("[TB] FAIL memwait done: got %h/%b/%b want 1234/1/0", bus, busVld, busy); end
    testsRun++; if (busSrc !== 3'd7) begin testsFailed++; $display("[TB] FAIL memwait bus_src: got %0d want 7", busSrc); end
    srcData[7*WIDTH +: WIDTH] = 16'h4321;
    sel = 8'h80; memRdy = 1'b1;
    tick();
    testsRun++; if ({bus, busVld, busy} !== {16'h4321, 1'b1, 1'b0}) begin testsFailed++; $display("[TB] FAIL mem immediate: got %h/%b/%b want 4321/1/0", bus, busVld, busy); end
    sel = 8'h00; memRdy = 1'b0;
    tick();
  endtask

  task automatic test_mem_timeout();
    int busyCycles;
    sel = 8'h04;
    tick();
    sel = 8'h80; memRdy = 1'b0;
    tick();
    sel = 8'h00;
    busyCycles = 0;
    while (busy === 1'b1 && busyCycles < 40) begin
      busyCycles++;
      tick();
    end
    testsRun++; if (busyCycles !== 15) begin testsFailed++; $display("[TB] FAIL timeout busy cycles: got %0d want 15", busyCycles); end
    testsRun++; if ({memTo, bus, busVld} !== {1'b1, 16'h0000, 1'b0}) begin testsFailed++; $display("[TB] FAIL timeout result: got %b/%h/%b want 1/0000/0", memTo, bus, busVld); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    testsRun++; if (memTo !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout clear: got %b want 0", memTo); end
  endtask

  task automatic test_timeout_race();
    srcData[7*WIDTH +: WIDTH] = 16'h7777;
    sel = 8'h80; memRdy = 1'b0;
    tick();
    sel = 8'h00;
    repeat (14) tick();
    testsRun++; if ({busy, memTo} !== 2'b10) begin testsFailed++; $display("[TB] FAIL race pre-edge busy/mem_to: got %b%b want 10", busy, memTo); end
    memRdy = 1'b1;
    tick();
    memRdy = 1'b0;
    testsRun++; if ({bus, busVld, busy, memTo} !== {16'h7777, 1'b1, 1'b0, 1'b0}) begin testsFailed++; $display("[TB] FAIL race rdy wins: got %h/%b/%b/%b want 7777/1/0/0", bus, busVld, busy, memTo); end
  endtask

  task automatic test_multi_hot();
    sel = 8'h04;
    tick();
    sel = 8'h06;
    tick();
    testsRun++; if ({selErr, bus, busVld, busy} !== {1'b1, 16'h0000, 1'b0, 1'b0}) begin testsFailed++; $display("[TB] FAIL multihot: got %b/%h/%b/%b want 1/0000/0/0", selErr, bus, busVld, busy); end
    sel = 8'h0A; errClr = 1'b1;
    tick();
    testsRun++; if (selErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL set wins over clear: got %b want 1", selErr); end
    sel = 8'h00;
    tick();
    errClr = 1'b0;
    testsRun++; if (selErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL sel_err clear: got %b want 0", selErr); end
  endtask

  task automatic test_hold();
    srcData[2*WIDTH +: WIDTH] = 16'hABCD;
    srcData[4*WIDTH +: WIDTH] = 16'h5555;
    sel = 8'h04;
    tick();
    hold = 1'b1; sel = 8'h10;
    repeat (2) tick();
    testsRun++; if ({bus, busVld, busSrc} !== {16'hABCD, 1'b1, 3'd2}) begin testsFailed++; $display("[TB] FAIL hold freeze: got %h/%b/%0d want abcd/1/2", bus, busVld, busSrc); end
    sel = 8'h30;
    tick();
    testsRun++; if ({selErr, bus} !== {1'b0, 16'hABCD}) begin testsFailed++; $display("[TB] FAIL hold multihot ignored: got %b/%h want 0/abcd", selErr, bus); end
    hold = 1'b0; sel = 8'h10;
    tick();
    testsRun++; if ({bus, busVld, busSrc} !== {16'h5555, 1'b1, 3'd4}) begin testsFailed++; $display("[TB] FAIL hold release: got %h/%b/%0d want 5555/1/4", bus, busVld, busSrc); end
  endtask

  task automatic test_back_to_back();
    srcData[3*WIDTH +: WIDTH] = 16'h0303;
    sel = 8'h08;
    for (int c = 0; c < 3; c++) begin
      tick();
      testsRun++; if ({bus, busVld} !== {16'h0303, 1'b1}) begin testsFailed++; $display("[TB] FAIL level cycle %0d: got %h/%b want 0303/1", c, bus, busVld); end
    end
    hold = 1'b1;
    srcData[3*WIDTH +: WIDTH] = 16'hBEEF;
    tick();
    testsRun++; if (bus !== 16'h0303) begin testsFailed++; $display("[TB] FAIL no resample: got %h want 0303", bus); end
    hold = 1'b0;
    tick();
    testsRun++; if (bus !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL resample: got %h want beef", bus); end
    sel = 8'h00;
    tick();
    testsRun++; if ({bus, busVld, busSrc} !== {16'h0000, 1'b0, 3'd3}) begin testsFailed++; $display("[TB] FAIL idle after 3: got %h/%b/%0d want 0000/0/3", bus, busVld, busSrc); end
  endtask

  task automatic test_async_reset();
    srcData[2*WIDTH +: WIDTH] = 16'hABCD;
    sel = 8'h06;
    tick();
    sel = 8'h04;
    tick();
    sel = 8'h80; memRdy = 1'b0;
    tick();
    sel = 8'h00;
    testsRun++; if ({busy, selErr, bus} !== {1'b1, 1'b1, 16'hABCD}) begin testsFailed++; $display("[TB] FAIL pre-reset state: got %b/%b/%h want 1/1/abcd", busy, selErr, bus); end
    #2;
    rstN = 1'b0;
    #1;
    testsRun++; if ({bus, busVld, busSrc} !== {16'h0000, 1'b0, 3'd0}) begin testsFailed++; $display("[TB] FAIL async reset bus: got %h/%b/%0d want 0000/0/0", bus, busVld, busSrc); end
    testsRun++; if ({busy, selErr, memTo} !== 3'b000) begin testsFailed++; $display("[TB] FAIL async reset flags: got %b want 000", {busy, selErr, memTo}); end
    @(negedge clk);
    rstN = 1'b1;
    tick();
    testsRun++; if ({busy, busVld} !== 2'b00) begin testsFailed++; $display("[TB] FAIL after reset release: got %b%b want 00", busy, busVld); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_select();
    test_mem_wait();
    test_mem_timeout();
    test_timeout_race();
    test_multi_hot();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
